gpio_cmd_sequencer: RTL and testbench
=====================================

# gpio_cmd_sequencer

Command sequencer between the processor-side GPIO command registers and the single-port BRAM holding the 8-element data table. Accepts a command over a four-phase go/done handshake. Fetches the addressed 32-bit word from BRAM, applies the selected operation (read, complement, offset, multiply), and presents a registered result plus status. It owns all BRAM read sequencing, so the BRAM is never enabled outside an accepted command.

## Interface
- `BRAM_LAT`, default 1: BRAM read latency in cycles, legal range 1..3.
- `DATA_W`, default 32: data/result width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd` in 8: command word; [0] go, [5:3] element index, [7:6] op (00 read, 01 complement, 10 offset, 11 multiply), [2:1] ignored.
- `mult` in 8: multiplier operand, unsigned.
- `offset` in 8: offset operand, unsigned.
- `bram_en` out 1: BRAM enable, high exactly one cycle per command.
- `bram_addr` out 32: byte address = index × 4 (0x00..0x1C).
- `bram_rdata` in DATA_W: BRAM read data, valid BRAM_LAT cycles after the `bram_en` cycle.
- `result` out DATA_W: registered operation result.
- `done` out 1: result valid; handshake acknowledge.
- `busy` out 1: high in ISSUE/WAIT/EXEC.

## Operation
- Reset values: `bram_en`=0, `bram_addr`=0, `result`=0, `done`=0, `busy`=0, state IDLE, armed=0.
- Armed flag: set whenever go (as seen by the FSM) is 0 in IDLE. A command is accepted only when armed=1, which blocks stale go held through reset.
- IDLE: if go=1 and armed=1, latch op, index, mult, offset, then go to ISSUE. All later `cmd`/`mult`/`offset` changes are ignored until the next accept.
- ISSUE, 1 cycle: `bram_en`=1, `bram_addr`={index,2'b00}. Then go to WAIT. `bram_addr` holds until the next ISSUE.
- WAIT, BRAM_LAT cycles, tracked by a down-counter: at the edge ending the last WAIT cycle, capture `bram_rdata` into data_q, then go to EXEC.
- EXEC, 1 cycle: load `result` per the op rules below, set `done`=1, then go to DONE.
  - read: data_q.
  - complement: ~data_q.
  - offset: data_q + zero-extended offset, modulo 2^32 (wraps, no flag).
  - multiply: low 32 bits of data_q × zero-extended mult.
- DONE: hold `result` and `done` while go=1; go held high never retriggers. When go=0: `done`←0, armed←1, go to IDLE. `result` holds until the next EXEC.
- Reset in any state: returns to reset values at that edge, with no further BRAM access for the aborted command.

## Timing
- Edge 0 is the first edge at which go=1 is sampled at the `cmd` port.
- With the synchronizer: ISSUE from edge 2, `done` rises at edge 4+BRAM_LAT.
- Without the synchronizer: ISSUE from edge 0, `done` rises at edge 2+BRAM_LAT.
- `done` falls at the edge when the FSM first sees go=0: 2 edges after the port change with the synchronizer, 0 without.
- Minimum command-to-command spacing: one IDLE cycle after DONE.

## Configuration
- `GPIO_CMD_SYNC_EN` defined: `cmd`, `mult`, `offset` pass through a 2-flop synchronizer, for GPIO in an asynchronous domain; adds 2 cycles as above.
- `GPIO_CMD_SYNC_EN` undefined: inputs are used directly and must be synchronous to `clk`.

## Structure
- Package `gpio_seq_pkg` holds:
  - state enum (IDLE, ISSUE, WAIT, EXEC, DONE);
  - op constants OP_READ/OP_COMPL/OP_OFFSET/OP_MULT;
  - cmd field positions;
  - ADDR_STRIDE=4.
- Sub-module `cdc_sync2` (parameter WIDTH): 2-flop synchronizer, instantiated only under `GPIO_CMD_SYNC_EN`.

## Test plan
BRAM model preloaded with 0x0C→0x000000F0 and 0x1C→0xFFFFFFFF; run all scenarios for BRAM_LAT=1 and 3, with the macro defined and undefined.
1. cmd=0x19 → one `bram_en` pulse with `bram_addr`=0x0C; `result`=0x000000F0; `done` at edge 4+BRAM_LAT (macro defined).
2. cmd=0x59 → `result`=0xFFFFFF0F; cmd=0x99 with offset=0x20 → `result`=0x00000110.
3. cmd=0xF9 with mult=0xFF → `bram_addr`=0x1C; `result`=0xFFFFFF01 (truncated product).
4. Hold go high 20 cycles past `done` → no second `bram_en`. Drop go → `done`=0 after 2 edges. Re-raise with cmd=0x59 → new result 0xFFFFFF0F.
5. Change `cmd` to 0xF9 and `mult` to 0x02 during WAIT → `result` still reflects the latched command.
6. Assert `reset` during WAIT with go held high → all outputs 0 and no `bram_en` after release. A go low→high sequence is then required before the next `bram_en`.

Source files
------------

// File: rtl/gpio_seq_pkg.sv
// Shared types and constants for the GPIO command sequencer: FSM states,
// operation codes, command-word field positions and BRAM address stride.
package gpio_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EXEC,
    DONE
  } state_e;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_COMPL  = 2'b01;
  localparam logic [1:0] OP_OFFSET = 2'b10;
  localparam logic [1:0] OP_MULT   = 2'b11;

  localparam int CMD_GO_BIT  = 0;
  localparam int CMD_IDX_LSB = 3;
  localparam int CMD_IDX_MSB = 5;
  localparam int CMD_OP_LSB  = 6;
  localparam int CMD_OP_MSB  = 7;

  localparam int ADDR_STRIDE = 4;

  // Byte address of a table element in the 32-bit-wide BRAM.
  function automatic logic [31:0] elemAddr(input logic [2:0] idx);
    return 32'(idx) * 32'(ADDR_STRIDE);
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for quasi-static GPIO fields. Deliberately not reset,
// so a go bit held through reset stays visible and the armed flag can block it.
module cdc_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_cmd_sequencer.sv
// Go/done command sequencer: fetches one BRAM word per accepted command and
// applies read/complement/offset/multiply. Define GPIO_CMD_SYNC_EN for async GPIO inputs.
module gpio_cmd_sequencer
  import gpio_seq_pkg::*;
#(
  parameter int BRAM_LAT = 1,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        cmd,
  input  logic [7:0]        mult,
  input  logic [7:0]        offset,
  output logic              bram_en,
  output logic [31:0]       bram_addr,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy
);

  localparam logic [1:0] WAIT_INIT = 2'(BRAM_LAT - 1);

  logic [7:0] cmdS;
  logic [7:0] multS;
  logic [7:0] offsetS;

`ifdef GPIO_CMD_SYNC_EN
  cdc_sync2 #(.WIDTH(24)) uSync (
    .clk (clk),
    .d_i ({cmd, mult, offset}),
    .q_o ({cmdS, multS, offsetS})
  );
`else
  assign cmdS    = cmd;
  assign multS   = mult;
  assign offsetS = offset;
`endif

  logic       go;
  logic [2:0] idx;
  logic [1:0] op;
  logic       unused_cmdBits;

  assign go             = cmdS[CMD_GO_BIT];
  assign idx            = cmdS[CMD_IDX_MSB:CMD_IDX_LSB];
  assign op             = cmdS[CMD_OP_MSB:CMD_OP_LSB];
  assign unused_cmdBits = ^cmdS[2:1];

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic [1:0]        op_q, op_d;
  logic [7:0]        mult_q, mult_d;
  logic [7:0]        offset_q, offset_d;
  logic [1:0]        waitCnt_q, waitCnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic [31:0]       addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      op_q      <= OP_READ;
      mult_q    <= '0;
      offset_q  <= '0;
      waitCnt_q <= '0;
      data_q    <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      op_q      <= op_d;
      mult_q    <= mult_d;
      offset_q  <= offset_d;
      waitCnt_q <= waitCnt_d;
      data_q    <= data_d;
      result_q  <= result_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
    end
  end

  // Operands are latched at accept, so port changes mid-command have no effect.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    op_d      = op_q;
    mult_d    = mult_q;
    offset_d  = offset_q;
    waitCnt_d = waitCnt_q;
    data_d    = data_q;
    result_d  = result_q;
    done_d    = done_q;
    addr_d    = addr_q;
    unique case (state_q)
      IDLE: begin
        if (go && armed_q) begin
          op_d     = op;
          mult_d   = multS;
          offset_d = offsetS;
          addr_d   = elemAddr(idx);
          armed_d  = 1'b0;
          state_d  = ISSUE;
        end else if (!go) begin
          armed_d = 1'b1;
        end
      end
      ISSUE: begin
        waitCnt_d = WAIT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        if (waitCnt_q == 2'd0) begin
          data_d  = bram_rdata;
          state_d = EXEC;
        end else begin
          waitCnt_d = waitCnt_q - 2'd1;
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_READ:   result_d = data_q;
          OP_COMPL:  result_d = ~data_q;
          OP_OFFSET: result_d = data_q + DATA_W'(offset_q);
          OP_MULT:   result_d = data_q * DATA_W'(mult_q);
          default:   result_d = data_q;
        endcase
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!go) begin
          done_d  = 1'b0;
          armed_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bram_en   = (state_q == ISSUE);
  assign bram_addr = addr_q;
  assign result    = result_q;
  assign done      = done_q;
  assign busy      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == EXEC);

endmodule

// File: tb/tb_gpio_cmd_sequencer.sv
// Self-checking bench for gpio_cmd_sequencer with a latency-accurate BRAM model
// and an arithmetic reference for the four operations.
module tb_gpio_cmd_sequencer;

  parameter int BRAM_LAT = 1;
  localparam int DATA_W = 32;
`ifdef GPIO_CMD_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        cmd;
  logic [7:0]        mult;
  logic [7:0]        offset;
  logic              bram_en;
  logic [31:0]       bram_addr;
  logic [DATA_W-1:0] bram_rdata;
  logic [DATA_W-1:0] result;
  logic              done;
  logic              busy;

  int          checks  = 0;
  int          errors  = 0;
  int          enCount = 0;
  logic [31:0] lastAddr = 32'hFFFF_FFFF;
  logic [31:0] tbMem [8];
  logic [31:0] pipe [BRAM_LAT];

  always #5 clk = ~clk;

  gpio_cmd_sequencer #(.BRAM_LAT(BRAM_LAT), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .mult       (mult),
    .offset     (offset),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_rdata (bram_rdata),
    .result     (result),
    .done       (done),
    .busy       (busy)
  );

  // BRAM: data for an enable cycle appears BRAM_LAT cycles later; garbage otherwise.
  always @(posedge clk) begin
    pipe[0] <= bram_en ? tbMem[bram_addr[4:2]] : 32'hDEAD_BEEF;
    for (int i = 1; i < BRAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_rdata = pipe[BRAM_LAT-1];

  always @(negedge clk) begin
    if (bram_en === 1'b1) begin
      enCount  = enCount + 1;
      lastAddr = bram_addr;
    end
  end

  function automatic logic [31:0] modelResult(input logic [1:0] op, input logic [31:0] w,
                                              input logic [7:0] m, input logic [7:0] o);
    longint unsigned full;
    case (op)
      2'd0:    full = longint'(w);
      2'd1:    full = 64'h0000_0000_FFFF_FFFF - longint'(w);
      2'd2:    full = longint'(w) + longint'(o);
      default: full = longint'(w) * longint'(m);
    endcase
    return full[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runCmd(input logic [7:0] c, input logic [7:0] m, input logic [7:0] o,
                        output int doneEdge, output int enDelta);
    int startEn;
    startEn  = enCount;
    cmd      = c;
    mult     = m;
    offset   = o;
    doneEdge = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done === 1'b1) begin
        doneEdge = k;
        break;
      end
    end
    enDelta = enCount - startEn;
  endtask

  task automatic releaseGo(output int fallEdge);
    cmd      = cmd & 8'hFE;
    fallEdge = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done === 1'b0) begin
        fallEdge = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd = 8'h00; mult = 8'h00; offset = 8'h00;
    repeat (3) tick();
    checks++; if (bram_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en got %b expected 0", bram_en); end
    checks++; if (bram_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h expected 0", bram_addr); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h expected 0", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_read();
    int de, en, fe;
    runCmd(8'h19, 8'h00, 8'h00, de, en);
    checks++; if (en !== 1) begin errors++; $display("[TB] FAIL read_enPulses got %0d expected 1", en); end
    checks++; if (lastAddr !== 32'h0C) begin errors++; $display("[TB] FAIL read_addr got %h expected 0000000c", lastAddr); end
    checks++; if (result !== 32'h0000_00F0) begin errors++; $display("[TB] FAIL read_result got %h expected 000000f0", result); end
    checks++; if (de !== 2 + SYNC_DLY + BRAM_LAT) begin errors++; $display("[TB] FAIL read_doneEdge got %0d expected %0d", de, 2 + SYNC_DLY + BRAM_LAT); end
    releaseGo(fe);
    checks++; if (fe !== SYNC_DLY) begin errors++; $display("[TB] FAIL read_fallEdge got %0d expected %0d", fe, SYNC_DLY); end
  endtask

  task automatic test_ops();
    int de, en, fe;
    runCmd(8'h59, 8'h00, 8'h00, de, en);
    checks++; if (result !== 32'hFFFF_FF0F) begin errors++; $display("[TB] FAIL compl_result got %h expected ffffff0f", result); end
    releaseGo(fe);
    runCmd(8'h99, 8'h00, 8'h20, de, en);
    checks++; if (result !== 32'h0000_0110) begin errors++; $display("[TB] FAIL offset_result got %h expected 00000110", result); end
    releaseGo(fe);
    runCmd(8'hF9, 8'hFF, 8'h00, de, en);
    checks++; if (lastAddr !== 32'h1C) begin errors++; $display("[TB] FAIL mult_addr got %h expected 0000001c", lastAddr); end
    checks++; if (result !== 32'hFFFF_FF01) begin errors++; $display("[TB] FAIL mult_result got %h expected ffffff01", result); end
    releaseGo(fe);
  endtask

  task automatic test_random();
    int de, en, fe;
    logic [2:0] idx;
    logic [1:0] op;
    logic [7:0] m, o, c;
    logic [31:0] exp;
    for (int n = 0; n < 12; n++) begin
      idx = 3'($urandom_range(0, 7));
      op  = 2'($urandom_range(0, 3));
      m   = 8'($urandom);
      o   = 8'($urandom);
      c   = {op, idx, 2'($urandom), 1'b1};
      exp = modelResult(op, tbMem[idx], m, o);
      runCmd(c, m, o, de, en);
      checks++; if (result !== exp) begin errors++; $display("[TB] FAIL rand_result cmd %h got %h expected %h", c, result, exp); end
      checks++; if (lastAddr !== 32'(idx) * 4) begin errors++; $display("[TB] FAIL rand_addr got %h expected %h", lastAddr, 32'(idx) * 4); end
      checks++; if (en !== 1) begin errors++; $display("[TB] FAIL rand_enPulses got %0d expected 1", en); end
      releaseGo(fe);
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_hold();
    int de, en, fe, startEn;
    runCmd(8'h19, 8'h00, 8'h00, de, en);
    startEn = enCount;
    repeat (20) tick();
    checks++; if (enCount - startEn !== 0) begin errors++; $display("[TB] FAIL hold_extraEn got %0d expected 0", enCount - startEn); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL hold_done got %b expected 1", done); end
    checks++; if (result !== 32'h0000_00F0) begin errors++; $display("[TB] FAIL hold_result got %h expected 000000f0", result); end
    releaseGo(fe);
    checks++; if (fe !== SYNC_DLY) begin errors++; $display("[TB] FAIL hold_fallEdge got %0d expected %0d", fe, SYNC_DLY); end
    tick();
    runCmd(8'h59, 8'h00, 8'h00, de, en);
    checks++; if (result !== 32'hFFFF_FF0F) begin errors++; $display("[TB] FAIL hold_reraise got %h expected ffffff0f", result); end
    checks++; if (en !== 1) begin errors++; $display("[TB] FAIL hold_reraiseEn got %0d expected 1", en); end
    releaseGo(fe);
  endtask

  task automatic test_change_during_wait();
    int de, en, fe;
    bit seen;
    cmd = 8'h19; mult = 8'h00; offset = 8'h00;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (bram_en === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL change_issue got none expected bram_en"); end
    tick();
    cmd = 8'hF9; mult = 8'h02;
    runCmd(8'hF9, 8'h02, 8'h00, de, en);
    checks++; if (result !== 32'h0000_00F0) begin errors++; $display("[TB] FAIL change_result got %h expected 000000f0", result); end
    checks++; if (lastAddr !== 32'h0C) begin errors++; $display("[TB] FAIL change_addr got %h expected 0000000c", lastAddr); end
    releaseGo(fe);
  endtask

  task automatic test_reset_abort();
    int de, en, startEn;
    bit seen;
    cmd = 8'h19; mult = 8'h00; offset = 8'h00;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (bram_en === 1'b1) seen = 1;
    end
    tick();
    checks++; if (!(seen && busy === 1'b1 && bram_en === 1'b0)) begin errors++; $display("[TB] FAIL abort_inWait got busy %b en %b expected busy 1 en 0", busy, bram_en); end
    reset = 1'b1;
    tick();
    checks++; if ({bram_en, done, busy} !== 3'b000) begin errors++; $display("[TB] FAIL abort_flags got %b expected 000", {bram_en, done, busy}); end
    checks++; if (result !== 32'h0 || bram_addr !== 32'h0) begin errors++; $display("[TB] FAIL abort_regs got %h/%h expected 0/0", result, bram_addr); end
    tick();
    reset = 1'b0;
    startEn = enCount;
    repeat (12) tick();
    checks++; if (enCount - startEn !== 0) begin errors++; $display("[TB] FAIL abort_staleGo got %0d expected 0", enCount - startEn); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle got busy %b done %b expected 0 0", busy, done); end
    cmd = 8'h18;
    repeat (SYNC_DLY + 2) tick();
    runCmd(8'h19, 8'h00, 8'h00, de, en);
    checks++; if (en !== 1) begin errors++; $display("[TB] FAIL abort_rearmEn got %0d expected 1", en); end
    checks++; if (result !== 32'h0000_00F0) begin errors++; $display("[TB] FAIL abort_rearmResult got %h expected 000000f0", result); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbMem[i] = $urandom;
    tbMem[3] = 32'h0000_00F0;
    tbMem[7] = 32'hFFFF_FFFF;
    test_reset();
    test_read();
    test_ops();
    test_random();
    test_hold();
    test_change_during_wait();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
